// File: rtl/sfifo_ctrl_if.sv
// Bus bundle between the command-stream writer, the FIFO/tick controller and the
// WISHBONE SFIFO interface. The "slave" modport is the controller's view.
interface sfifo_ctrl_if #(
    parameter int DW  = 16,
    parameter int AW  = 4,
    parameter int BPW = 16
);
    // Write side: a word is taken on a rising edge where wr_i=1 and room exists.
    logic           wr_i;
    logic [DW-1:0]  wr_data_i;
    logic           full_o;

    // Read side: rd_data_o is the head word whenever empty_o=0; rd_i pops it.
    logic           rd_i;
    logic [DW-1:0]  rd_data_o;
    logic           empty_o;
    logic [AW:0]    level_o;

    // Sticky status and base-period tick.
    logic           ovf_o;
    logic           udf_o;
    logic           flag_clr_i;
    logic           bp_en_i;
    logic [BPW-1:0] bp_period_i;
    logic           bp_tick_o;

    modport slave (
        input  wr_i,
        input  wr_data_i,
        output full_o,
        input  rd_i,
        output rd_data_o,
        output empty_o,
        output level_o,
        output ovf_o,
        output udf_o,
        input  flag_clr_i,
        input  bp_en_i,
        input  bp_period_i,
        output bp_tick_o
    );

    modport master (
        output wr_i,
        output wr_data_i,
        input  full_o,
        output rd_i,
        input  rd_data_o,
        input  empty_o,
        input  level_o,
        input  ovf_o,
        input  udf_o,
        output flag_clr_i,
        output bp_en_i,
        output bp_period_i,
        input  bp_tick_o
    );
endinterface

// File: rtl/sfifo_ctrl.sv
// Single-clock first-word-fall-through sync-word FIFO with sticky over/underflow
// flags and a programmable base-period tick generator for the SFIFO interface.
module sfifo_ctrl #(
    parameter int DW  = 16,
    parameter int AW  = 4,
    parameter int BPW = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    sfifo_ctrl_if.slave bus
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [DW-1:0]  mem_q [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;
    logic           ovf_q,    ovf_d;
    logic           udf_q,    udf_d;
    logic [BPW-1:0] bp_cnt_q, bp_cnt_d;
    logic           bp_tick_q, bp_tick_d;

    logic           full;
    logic           empty;
    logic           rd_acc;
    logic           wr_acc;
    logic [BPW-1:0] bp_last;

    // All status is derived from the registered count, so there is no path
    // from wr_i/rd_i to any output.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write
    // when it is also being read.
    assign rd_acc = bus.rd_i & ~empty;
    assign wr_acc = bus.wr_i & (~full | rd_acc);

    // ------------------------------------------------------------------
    // Pointer, occupancy and flag next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Clear is applied first so a same-cycle event still leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;

        if (bus.flag_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (bus.wr_i && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (bus.rd_i && empty) begin
            udf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Base-period tick generator
    // ------------------------------------------------------------------
    // Period 0 behaves like period 1; comparing with >= makes a period that
    // drops below the running count fire on the next edge and restart.
    always_comb begin
        bp_last = '0;
        if (bus.bp_period_i != '0) begin
            bp_last = bus.bp_period_i - BPW'(1);
        end
    end

    always_comb begin
        bp_cnt_d  = '0;
        bp_tick_d = 1'b0;

        if (bus.bp_en_i) begin
            if (bp_cnt_q >= bp_last) begin
                bp_cnt_d  = '0;
                bp_tick_d = 1'b1;
            end else begin
                bp_cnt_d  = bp_cnt_q + BPW'(1);
                bp_tick_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            bp_cnt_q  <= '0;
            bp_tick_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            bp_cnt_q  <= bp_cnt_d;
            bp_tick_q <= bp_tick_d;
        end
    end

    // Word storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.wr_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.full_o    = full;
    assign bus.empty_o   = empty;
    assign bus.level_o   = count_q;
    assign bus.rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.ovf_o     = ovf_q;
    assign bus.udf_o     = udf_q;
    assign bus.bp_tick_o = bp_tick_q;

endmodule

// File: tb/tb_sfifo_ctrl.sv
// Directed bench for sfifo_ctrl: a queue of expected words is filled as writes are
// issued and a monitor pops and compares on every accepted read.
module tb_sfifo_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int BPW = 16;

    logic clk_i;
    logic rst_n_i;

    int checks;
    int errors;

    logic [DW-1:0] exp_q[$];

    sfifo_ctrl_if #(.DW(DW), .AW(AW), .BPW(BPW)) bus ();

    sfifo_ctrl #(.DW(DW), .AW(AW), .BPW(BPW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_status(input string tag, input int lvl, input logic emp,
                                 input logic ful, input logic [DW-1:0] rdat,
                                 input logic ovf, input logic udf);
        @(negedge clk_i);
        chk({tag, ".level"}, 32'(bus.level_o), 32'(lvl));
        chk({tag, ".empty"}, 32'(bus.empty_o), 32'(emp));
        chk({tag, ".full"},  32'(bus.full_o),  32'(ful));
        chk({tag, ".rdata"}, 32'(bus.rd_data_o), 32'(rdat));
        chk({tag, ".ovf"},   32'(bus.ovf_o),   32'(ovf));
        chk({tag, ".udf"},   32'(bus.udf_o),   32'(udf));
        @(posedge clk_i);
        #1;
    endtask

    // Compares the head word on every accepted pop against the scoreboard.
    task automatic monitor();
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && bus.rd_i && !bus.empty_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no word", bus.rd_data_o);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("pop_data", 32'(bus.rd_data_o), 32'(exp_w));
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.wr_i      = 1'b1;
        bus.wr_data_i = d;
        exp_q.push_back(d);
        step();
        bus.wr_i      = 1'b0;
    endtask

    task automatic push_drop(input logic [DW-1:0] d);
        bus.wr_i      = 1'b1;
        bus.wr_data_i = d;
        step();
        bus.wr_i      = 1'b0;
    endtask

    task automatic pop();
        bus.rd_i = 1'b1;
        step();
        bus.rd_i = 1'b0;
    endtask

    task automatic rdwr(input logic [DW-1:0] d);
        bus.wr_i      = 1'b1;
        bus.rd_i      = 1'b1;
        bus.wr_data_i = d;
        exp_q.push_back(d);
        step();
        bus.wr_i      = 1'b0;
        bus.rd_i      = 1'b0;
    endtask

    task automatic clr();
        bus.flag_clr_i = 1'b1;
        step();
        bus.flag_clr_i = 1'b0;
    endtask

    task automatic tick_edge(input string name, input logic exp);
        @(posedge clk_i);
        @(negedge clk_i);
        chk(name, 32'(bus.bp_tick_o), 32'(exp));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        checks          = 0;
        errors          = 0;
        rst_n_i         = 1'b0;
        bus.wr_i        = 1'b0;
        bus.wr_data_i   = '0;
        bus.rd_i        = 1'b0;
        bus.flag_clr_i  = 1'b0;
        bus.bp_en_i     = 1'b0;
        bus.bp_period_i = '0;

        fork
            monitor();
        join_none

        expect_status("in_reset", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n_i = 1'b1;
        expect_status("reset", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("reset.tick", 32'(bus.bp_tick_o), 32'd0);
        step();

        // Two writes, one pop
        push(16'h1111);
        expect_status("w1", 1, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0);
        push(16'h2222);
        expect_status("w2", 2, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0);
        pop();
        expect_status("p1", 1, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0);
        pop();

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) push(16'(i));
        expect_status("fill", 16, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        push_drop(16'hDEAD);
        expect_status("ovf", 16, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) pop();
        expect_status("drain", 0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Simultaneous read+write on full, then pointer wrap
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
        clr();
        expect_status("refill", 16, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        rdwr(16'hBEEF);
        expect_status("full_rw", 16, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) rdwr(16'h3000 + 16'(i));
        expect_status("wrap", 16, 1'b0, 1'b1, 16'h3018, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) pop();
        expect_status("wrap_drain", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Underflow and empty read+write
        pop();
        expect_status("udf", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        rdwr(16'h5A5A);
        expect_status("empty_rw", 1, 1'b0, 1'b0, 16'h5A5A, 1'b0, 1'b1);
        clr();
        expect_status("clr", 1, 1'b0, 1'b0, 16'h5A5A, 1'b0, 1'b0);
        pop();
        bus.rd_i       = 1'b1;
        bus.flag_clr_i = 1'b1;
        step();
        bus.rd_i       = 1'b0;
        bus.flag_clr_i = 1'b0;
        expect_status("set_wins", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        clr();
        expect_status("clr2", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Tick generator: period 5, then 2 while count is 3, then disabled
        bus.bp_period_i = 16'd5;
        bus.bp_en_i     = 1'b1;
        for (int k = 1; k <= 23; k++) tick_edge("tick_p5", (k % 5) == 0);
        bus.bp_period_i = 16'd2;
        for (int k = 24; k <= 31; k++) tick_edge("tick_p2", (k % 2) == 0);
        bus.bp_en_i = 1'b0;
        for (int k = 0; k < 6; k++) tick_edge("tick_off", 1'b0);
        bus.bp_period_i = 16'd1;
        bus.bp_en_i     = 1'b1;
        for (int k = 0; k < 4; k++) tick_edge("tick_p1", 1'b1);
        bus.bp_period_i = 16'd0;
        for (int k = 0; k < 3; k++) tick_edge("tick_p0", 1'b1);
        bus.bp_en_i = 1'b0;
        tick_edge("tick_stop", 1'b0);
        step();

        // Asynchronous reset in the middle of activity
        for (int i = 0; i < 16; i++) push(16'h7000 + 16'(i));
        push_drop(16'hDEAD);
        for (int i = 0; i < 9; i++) pop();
        expect_status("pre_rst", 7, 1'b0, 1'b0, 16'h7009, 1'b1, 1'b0);
        bus.bp_period_i = 16'd1;
        bus.bp_en_i     = 1'b1;
        step();
        step();
        @(negedge clk_i);
        chk("pre_rst.tick", 32'(bus.bp_tick_o), 32'd1);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("async_rst.level", 32'(bus.level_o),   32'd0);
        chk("async_rst.empty", 32'(bus.empty_o),   32'd1);
        chk("async_rst.full",  32'(bus.full_o),    32'd0);
        chk("async_rst.rdata", 32'(bus.rd_data_o), 32'd0);
        chk("async_rst.ovf",   32'(bus.ovf_o),     32'd0);
        chk("async_rst.udf",   32'(bus.udf_o),     32'd0);
        chk("async_rst.tick",  32'(bus.bp_tick_o), 32'd0);
        exp_q.delete();
        bus.bp_en_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        expect_status("post_rst", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        push(16'hA5A5);
        expect_status("post_rst_w", 1, 1'b0, 1'b0, 16'hA5A5, 1'b0, 1'b0);
        pop();
        expect_status("post_rst_p", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        chk("leftover_words", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
